stream_from_memory_burst: RTL

STREAM_FROM_MEMORY_BURST -- requirements
Module: stream_from_memory_burst

---
 rtl/stream_from_memory_burst.sv | 128 ++++++++++++
 1 files changed

// File: rtl/stream_from_memory_burst.sv
// Replays a memory region as a word stream, one word per downstream request,
// repeated a programmable number of times with idle gaps between packets.
module stream_from_memory_burst #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 11,
  parameter int REPEAT_WIDTH = 8,
  parameter int GAP_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   read_start,
  input  logic [ADDR_WIDTH-1:0]   read_end,
  input  logic [REPEAT_WIDTH-1:0] repeats,
  input  logic [GAP_WIDTH-1:0]    gap_cycles,
  input  logic                    readclk,
  output logic                    ram_readclk,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  input  logic                    ram_outclk,
  input  logic [DATA_WIDTH-1:0]   ram_out,
  output logic                    outclk,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    busy,
  output logic                    done
);

  // state     | meaning
  // IDLE      | no burst active
  // WAIT_REQ  | waiting for a downstream request, or at end of packet
  // WAIT_DATA | one memory read outstanding
  // GAP       | counting idle cycles between packets
  // DONE      | burst finished, done pulse is high
  typedef enum logic [2:0] {IDLE, WAIT_REQ, WAIT_DATA, GAP, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   start_r;
  logic [ADDR_WIDTH-1:0]   end_r;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [REPEAT_WIDTH-1:0] pkt_left;
  logic [GAP_WIDTH-1:0]    gap_r;
  logic [GAP_WIDTH-1:0]    gap_cnt;
  logic                    pending;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_r     <= '0;
      end_r       <= '0;
      addr        <= '0;
      pkt_left    <= '0;
      gap_r       <= '0;
      gap_cnt     <= '0;
      pending     <= 1'b0;
      ram_readclk <= 1'b0;
      ram_raddr   <= '0;
      outclk      <= 1'b0;
      out         <= '0;
      done        <= 1'b0;
    end else begin
      ram_readclk <= 1'b0;
      outclk      <= 1'b0;
      done        <= 1'b0;
      if (start) begin
        // Restart from any state; leaving WAIT_DATA makes any in-flight data ignored.
        start_r  <= read_start;
        end_r    <= read_end;
        gap_r    <= gap_cycles;
        pkt_left <= (repeats == '0) ? REPEAT_WIDTH'(1) : repeats;
        addr     <= read_start;
        gap_cnt  <= '0;
        pending  <= 1'b0;
        state    <= WAIT_REQ;
      end else begin
        case (state)
          IDLE: ;
          WAIT_REQ: begin
            if (addr != end_r) begin
              if (readclk || pending) begin
                ram_readclk <= 1'b1;
                ram_raddr   <= addr;
                pending     <= 1'b0;
                state       <= WAIT_DATA;
              end
            end else if (pkt_left > REPEAT_WIDTH'(1)) begin
              pkt_left <= pkt_left - 1'b1;
              if (gap_r == '0) begin
                addr <= start_r;
              end else begin
                gap_cnt <= gap_r;
                state   <= GAP;
              end
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          WAIT_DATA: begin
            if (readclk) pending <= 1'b1;
            if (ram_outclk) begin
              outclk <= 1'b1;
              out    <= ram_out;
              addr   <= addr + 1'b1;
              state  <= WAIT_REQ;
            end
          end
          GAP: begin
            if (readclk) pending <= 1'b1;
            if (gap_cnt <= GAP_WIDTH'(1)) begin
              gap_cnt <= '0;
              addr    <= start_r;
              state   <= WAIT_REQ;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          DONE: begin
            pending <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
